// File: rtl/seq_divider_8.sv
// Restoring unsigned sequential divider: one quotient bit per clock, MSB first.
// Define DIV_ZERO_DETECT_EN to add the dbz port and a two-edge early exit on a zero divisor.
module seq_divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             dbz
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic             accept;
    logic             last;
    logic             zero_exit;
    logic             finish;

    // The partial remainder stays below the divisor, so the (WIDTH+1)-bit
    // difference never overflows and its MSB is an exact borrow flag.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem_in,
        input logic [WIDTH-1:0] dvd_in,
        input logic [WIDTH-1:0] dvs_in
    );
        logic [WIDTH:0]   trial;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] rem_out;
        logic             qbit;
        trial   = {rem_in, dvd_in[WIDTH-1]};
        diff    = trial - {1'b0, dvs_in};
        qbit    = ~diff[WIDTH];
        rem_out = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        return {rem_out, dvd_in[WIDTH-2:0], qbit};
    endfunction

    assign {rem_step, dvd_step} = div_step(rem, dvd, dvs);

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == LAST_CNT);

`ifdef DIV_ZERO_DETECT_EN
    assign zero_exit = (state == RUN) && (dvs == '0);
`else
    assign zero_exit = 1'b0;
`endif

    assign finish = last || zero_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // dvd doubles as the quotient shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            q    <= '0;
            r    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz  <= 1'b0;
`endif
            if (accept) begin
                dvd  <= a;
                dvs  <= b;
                rem  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (state == RUN) begin
                rem <= rem_step;
                dvd <= dvd_step;
                cnt <= cnt + CNT_W'(1);
                if (finish) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (zero_exit) begin
                        q <= '1;
                        r <= dvd;
`ifdef DIV_ZERO_DETECT_EN
                        dbz <= 1'b1;
`endif
                    end else begin
                        q <= dvd_step;
                        r <= rem_step;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seq_divider_8.md
SEQ_DIVIDER_8 -- requirements
Module: seq_divider_8

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; all values below assume WIDTH=8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; SHALL be sampled on rising clk edges.
REQ-005 a  input  WIDTH  dividend; SHALL be captured on an accepted start.
REQ-006 b  input  WIDTH  divisor; SHALL be captured on an accepted start.
REQ-007 q  output  WIDTH  quotient, registered.
REQ-008 r  output  WIDTH  remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; q and r are valid in the same cycle.
REQ-011 dbz  output  1  divide-by-zero flag; this port exists only when DIV_ZERO_DETECT_EN is defined.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 A start SHALL be accepted when the FSM is in IDLE or DONE.
REQ-014 On acceptance (edge E0), the block SHALL latch a and b, clear the partial remainder, set busy=1 and enter RUN.
REQ-015 A start seen while in RUN SHALL be ignored, and the latched operands SHALL stay unchanged.
REQ-016 RUN SHALL run a restoring algorithm, one quotient bit per edge, MSB first:
- shift {rem, dividend} left by 1;
- trial-subtract the divisor from rem using a (WIDTH+1)-bit difference;
- if the difference is non-negative, keep it and set the quotient bit to 1;
- otherwise, restore rem and set the quotient bit to 0.
REQ-017 RUN SHALL last exactly WIDTH edges (E1..E8).
REQ-018 At E8, the block SHALL load q and r, drop busy to 0 and enter DONE.
REQ-019 Latency SHALL be done=1 in the cycle following E8, i.e. 9 edges after start is sampled.
REQ-020 DONE SHALL last one cycle; the FSM SHALL then return to IDLE unless start is sampled, in which case it enters RUN directly (back-to-back operation).
REQ-021 q and r SHALL hold their values until the next completion; they SHALL NOT change during RUN.
REQ-022 done SHALL be 0 in every cycle except the single DONE cycle.
REQ-023 Divisor 0 without the macro SHALL follow the normal algorithm and give q=all-ones, r=a.
REQ-024 Results SHALL be unsigned for all 256x256 operand pairs: q=floor(a/b) and r=a mod b.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, q=0, r=0, busy=0, done=0 and dbz=0, and clear the internal registers, independent of clk.
REQ-026 A reset during RUN SHALL abort the operation; no done SHALL follow it.
REQ-027 After release, the first start SHALL be accepted normally.

Configuration
REQ-028 The macro DIV_ZERO_DETECT_EN SHALL compile the divide-by-zero feature in or out.
REQ-029 With DIV_ZERO_DETECT_EN defined, an accepted start with b=0 SHALL:
- skip RUN and enter DONE at E1;
- set q=all-ones, r=a;
- pulse dbz=1 together with done (latency 2 edges);
- busy SHALL be high for one cycle only.
REQ-030 With DIV_ZERO_DETECT_EN defined, dbz SHALL be 0 on every non-zero-divisor completion.
REQ-031 Without DIV_ZERO_DETECT_EN, the dbz port SHALL be absent and b=0 SHALL follow REQ-023 with the full 9-edge latency.

Verification
REQ-032 a=100, b=7, start -> done 9 edges later; q=14, r=2; busy high for 8 cycles.
REQ-033 a=8'hA5, b=8'h5A -> q=8'h01, r=8'h4B; then a=8'hFF, b=8'h01 -> q=8'hFF, r=8'h00; then a=8'h05, b=8'h09 -> q=8'h00, r=8'h05.
REQ-034 Back-to-back: start held high across the DONE cycle with new a=8'h40, b=8'h08 -> second done exactly 9 edges after the first; q=8'h08, r=0.
REQ-035 start pulsed at E3 with different operands during RUN -> ignored; the first result is unchanged.
REQ-036 rst_n low at E4 of 200/3 -> all outputs 0 asynchronously, no done; next start 200/3 -> q=66, r=2.
REQ-037 a=8'h37, b=0:
- with DIV_ZERO_DETECT_EN: done and dbz high 2 edges after start, q=8'hFF, r=8'h37;
- without DIV_ZERO_DETECT_EN: the same values at 9 edges.
